vcd_down_counter: RTL and testbench
===================================

// Module: vcd_down_counter
// PURPOSE
//  Loadable, cascadable binary down-counter with clock enable and synchronous clear.
//  Mirror of the VCB up-counter family: the VCB counts up and flags all-ones.
//  This block counts a loaded value down and flags zero.
//  Used as a programmable period/timeout generator. Its CEO drives the ce of the next stage or a consumer.
//  A one-shot and an auto-reload mode are selected per load.
// PARAMETERS
//  WIDTH  4  counter width in bits (WIDTH >= 2)
// PORTS
//  clk   in   1      rising-edge clock; the only clock
//  clr   in   1      synchronous, active-high reset; highest priority
//  ce    in   1      count enable; qualifies every decrement
//  ld    in   1      load strobe; captures din and arl
//  din   in   WIDTH  load value (start count and reload value)
//  arl   in   1      auto-reload select, sampled only when ld=1
//  Q     out  WIDTH  current count (registered)
//  TC    out  1      terminal count: state==RUN && Q==0 (combinational)
//  CEO   out  1      cascade enable: TC & ce (combinational)
//  busy  out  1      state==RUN (combinational from state)
// BEHAVIOUR
//  Registers and states:
//  - Registers: Q, rld (WIDTH), arl_r (1), state in {IDLE, RUN, HOLD}.
//  - Reset: clr=1 at an edge -> Q=0, rld=0, arl_r=0, state=IDLE.
//  - After reset: TC=0, CEO=0, busy=0.
//  Priority per edge: clr > ld > count.
//  - ld=1 (any state) -> Q<=din, rld<=din, arl_r<=arl, state<=RUN.
//    - No decrement on the load edge, even if ce=1.
//  - IDLE and HOLD: ce ignored; Q holds.
//  - RUN, ce=1, Q!=0 -> Q<=Q-1.
//  - RUN, ce=1, Q==0 (terminal edge; CEO=1 during this cycle):
//    - arl_r=1 -> Q<=rld, stay RUN.
//    - arl_r=0 -> Q stays 0, state<=HOLD.
//  - RUN, ce=0 -> hold.
//  Timing:
//  - Period (auto-reload, ce always 1) = din+1 clk cycles; CEO is high for 1 cycle per period.
//  - With ce pulsing every Nth clk: period = (din+1)*N clk cycles.
//  - Latency from ld edge to the first CEO, with ce continuously 1: din clk cycles.
//    - The TC cycle is the din-th cycle after the load edge.
//  Boundary cases:
//  - din=0: TC is high immediately after load.
//    - With arl=1: CEO=ce every cycle.
//    - With arl=0: one CEO, then HOLD.
//  - din=2^WIDTH-1: full-range count. No wrap-around below 0 ever occurs; Q never goes 0 -> all-ones by decrement.
//  - ld in the terminal cycle: the load wins. CEO still reflects the current-cycle TC&ce, so the terminal event is emitted.
//  - clr mid-count: Q=0 and IDLE on the next edge. No CEO after that edge.
//  - CEO is combinational from ce; ce is held stable around clk edges.
// TESTING
//  (clk period 20 ns; ce toggles at 40 ns period unless stated)
//  1. Reset: clr=1 for 1 edge -> Q=0, TC=0, CEO=0, busy=0. ce pulses leave Q=0.
//  2. One-shot: ld din=4'd5 arl=0, ce=1 continuously.
//     - Q steps 5,4,3,2,1,0.
//     - CEO=1 for exactly 1 cycle at Q=0.
//     - Then HOLD: busy=0, Q=0.
//  3. Auto-reload: ld din=4'd3 arl=1, ce=1 -> Q cycles 3,2,1,0,3,...; CEO every 4th cycle; busy stays 1.
//  4. Gated ce (40 ns period), din=4'd2 arl=1 -> CEO pulse every 120 ns (3 ce pulses); Q changes only on ce=1 edges.
//  5. Edge cases:
//     - din=0 arl=1 -> CEO==ce every cycle.
//     - din=4'hF -> 16-cycle period; no wrap to F via decrement.
//  6. Collisions:
//     - clr=1 asserted at Q=7 mid-count with ld=1 the same edge -> clr wins: Q=0, IDLE.
//     - ld with ce=1 -> Q=din that edge, no decrement.

Source files
------------

// File: rtl/vcd_down_counter.sv
// Loadable, cascadable down-counter with clock enable and synchronous clear.
// Counts a loaded value down to zero and flags it; one-shot or auto-reload is chosen per load.
module vcd_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             arl,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CEO,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] rld, rldNext;
  logic [WIDTH-1:0] qNext;
  logic             arl_r, arlNext;

  // State register; clr overrides every other action on the same edge
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      Q     <= '0;
      rld   <= '0;
      arl_r <= 1'b0;
    end else begin
      state <= stateNext;
      Q     <= qNext;
      rld   <= rldNext;
      arl_r <= arlNext;
    end
  end

  // Load beats counting; the terminal decision is taken at zero so there is never a wrap to all-ones
  always_comb begin
    stateNext = state;
    qNext     = Q;
    rldNext   = rld;
    arlNext   = arl_r;
    if (ld) begin
      qNext     = din;
      rldNext   = din;
      arlNext   = arl;
      stateNext = RUN;
    end else begin
      case (state)
        RUN: begin
          if (ce) begin
            if (Q != '0) begin
              qNext = Q - 1'b1;
            end else if (arl_r) begin
              qNext = rld;
            end else begin
              stateNext = HOLD;
            end
          end
        end
        default: begin
          qNext = Q;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign TC   = busy && (Q == '0);
  assign CEO  = TC & ce;

endmodule

// File: tb/tb_vcd_down_counter.sv
// Directed self-checking bench for vcd_down_counter (WIDTH=4).
module tb_vcd_down_counter;

  logic       clk = 1'b0;
  logic       clr, ce, ld, arl;
  logic [3:0] din;
  logic [3:0] Q;
  logic       TC, CEO, busy;
  int         errors = 0;
  int         checks = 0;

  vcd_down_counter #(.WIDTH(4)) dut (
    .clk(clk), .clr(clr), .ce(ce), .ld(ld), .din(din), .arl(arl),
    .Q(Q), .TC(TC), .CEO(CEO), .busy(busy)
  );

  always #10 clk = ~clk;

  // Advance one edge and settle; inputs are changed only away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] value, input logic autoReload, input logic ceVal);
    ld = 1'b1; din = value; arl = autoReload; ce = ceVal;
    tick();
    ld = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; ce = 1'b0; ld = 1'b0; din = 4'd0; arl = 1'b0;
    tick();
    clr = 1'b0;
    checks++; if (Q !== 4'd0) begin errors++; $display("[TB] FAIL reset_q got=%0d exp=0", Q); end
    checks++; if (TC !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc got=%b exp=0", TC); end
    checks++; if (CEO !== 1'b0) begin errors++; $display("[TB] FAIL reset_ceo got=%b exp=0", CEO); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    for (int i = 0; i < 4; i++) begin
      ce = (i % 2 == 0);
      tick();
      checks++; if (Q !== 4'd0 || CEO !== 1'b0) begin errors++; $display("[TB] FAIL idle_hold i=%0d q=%0d ceo=%b exp q=0 ceo=0", i, Q, CEO); end
    end
  endtask

  task automatic test_one_shot();
    load(4'd5, 1'b0, 1'b1);
    for (int k = 5; k >= 0; k--) begin
      checks++; if (Q !== 4'(k)) begin errors++; $display("[TB] FAIL oneshot_q got=%0d exp=%0d", Q, k); end
      checks++; if (CEO !== (k == 0)) begin errors++; $display("[TB] FAIL oneshot_ceo k=%0d got=%b exp=%b", k, CEO, (k == 0)); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL oneshot_busy k=%0d got=%b exp=1", k, busy); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (Q !== 4'd0 || busy !== 1'b0 || CEO !== 1'b0) begin
        errors++; $display("[TB] FAIL oneshot_hold q=%0d busy=%b ceo=%b exp q=0 busy=0 ceo=0", Q, busy, CEO);
      end
      tick();
    end
  endtask

  task automatic test_auto_reload();
    logic [3:0] expQ [12] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
    load(4'd3, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      checks++; if (Q !== expQ[i] || CEO !== (i % 4 == 3) || busy !== 1'b1) begin
        errors++; $display("[TB] FAIL autoreload i=%0d q=%0d ceo=%b busy=%b exp q=%0d ceo=%b busy=1", i, Q, CEO, busy, expQ[i], (i % 4 == 3));
      end
      tick();
    end
  endtask

  task automatic test_gated_ce();
    logic [3:0] expQ [12]   = '{4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd2};
    logic       expCeo [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    load(4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      ce = (i % 2 == 0);
      #1;
      checks++; if (Q !== expQ[i] || CEO !== expCeo[i]) begin
        errors++; $display("[TB] FAIL gated_ce i=%0d q=%0d ceo=%b exp q=%0d ceo=%b", i, Q, CEO, expQ[i], expCeo[i]);
      end
      tick();
    end
    ce = 1'b0;
  endtask

  task automatic test_edges();
    logic [7:0] cePat;
    cePat = 8'b1011_0010;
    load(4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ce = cePat[i];
      #1;
      checks++; if (Q !== 4'd0 || TC !== 1'b1 || CEO !== cePat[i]) begin
        errors++; $display("[TB] FAIL din0_reload i=%0d q=%0d tc=%b ceo=%b exp q=0 tc=1 ceo=%b", i, Q, TC, CEO, cePat[i]);
      end
      tick();
    end
    load(4'd0, 1'b0, 1'b1);
    checks++; if (CEO !== 1'b1) begin errors++; $display("[TB] FAIL din0_oneshot_ceo got=%b exp=1", CEO); end
    tick();
    checks++; if (busy !== 1'b0 || CEO !== 1'b0) begin errors++; $display("[TB] FAIL din0_oneshot_hold busy=%b ceo=%b exp 0 0", busy, CEO); end
    load(4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      checks++; if (Q !== 4'(15 - i) || TC !== (i == 15)) begin
        errors++; $display("[TB] FAIL fullrange i=%0d q=%0d tc=%b exp q=%0d tc=%b", i, Q, TC, 15 - i, (i == 15));
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (Q !== 4'd0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL no_wrap i=%0d q=%0d busy=%b exp q=0 busy=0", i, Q, busy); end
      tick();
    end
  endtask

  task automatic test_collisions();
    load(4'd9, 1'b0, 1'b1);
    tick(); tick();
    checks++; if (Q !== 4'd7) begin errors++; $display("[TB] FAIL midcount_q got=%0d exp=7", Q); end
    clr = 1'b1; ld = 1'b1; din = 4'd3;
    tick();
    clr = 1'b0; ld = 1'b0;
    checks++; if (Q !== 4'd0 || busy !== 1'b0 || TC !== 1'b0 || CEO !== 1'b0) begin
      errors++; $display("[TB] FAIL clr_wins q=%0d busy=%b tc=%b ceo=%b exp 0 0 0 0", Q, busy, TC, CEO);
    end
    tick();
    checks++; if (Q !== 4'd0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL clr_stays q=%0d busy=%b exp 0 0", Q, busy); end
    load(4'd6, 1'b0, 1'b1);
    checks++; if (Q !== 4'd6) begin errors++; $display("[TB] FAIL ld_no_dec got=%0d exp=6", Q); end
    load(4'd1, 1'b0, 1'b1);
    tick();
    ld = 1'b1; din = 4'd4; arl = 1'b0;
    #1;
    checks++; if (CEO !== 1'b1 || TC !== 1'b1) begin errors++; $display("[TB] FAIL ld_terminal_ceo ceo=%b tc=%b exp 1 1", CEO, TC); end
    tick();
    ld = 1'b0;
    checks++; if (Q !== 4'd4 || busy !== 1'b1) begin errors++; $display("[TB] FAIL ld_terminal_wins q=%0d busy=%b exp q=4 busy=1", Q, busy); end
    tick();
    checks++; if (Q !== 4'd3) begin errors++; $display("[TB] FAIL after_reload_q got=%0d exp=3", Q); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_gated_ce();
    test_edges();
    test_collisions();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
